// File: rtl/jrb8_pkg.sv
// Shared definitions for the jump-resolution unit and its condition evaluator:
// condition codes, flag bit positions and FSM state encoding.
package jrb8_pkg;

    localparam logic [3:0] COND_ALWAYS = 4'h0;
    localparam logic [3:0] COND_EQ     = 4'h1;
    localparam logic [3:0] COND_NE     = 4'h2;
    localparam logic [3:0] COND_LT     = 4'h3;
    localparam logic [3:0] COND_LE     = 4'h4;
    localparam logic [3:0] COND_GT     = 4'h5;
    localparam logic [3:0] COND_GE     = 4'h6;
    localparam logic [3:0] COND_C      = 4'h7;
    localparam logic [3:0] COND_NC     = 4'h8;
    localparam logic [3:0] COND_O      = 4'h9;
    localparam logic [3:0] COND_NO     = 4'hA;
    localparam logic [3:0] COND_S      = 4'hB;
    localparam logic [3:0] COND_NS     = 4'hC;
    localparam logic [3:0] COND_HI     = 4'hD;
    localparam logic [3:0] COND_LS     = 4'hE;
    localparam logic [3:0] COND_NEVER  = 4'hF;

    localparam int FLAG_Z = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 0;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH_HI = 2'd1;
    localparam logic [1:0] ST_FETCH_LO = 2'd2;
    localparam logic [1:0] ST_COMMIT   = 2'd3;

endpackage

// File: rtl/jmp_cond_eval.sv
// Combinational condition evaluator: cond (4b) x flags {Z,O,C,S} -> result.
// Ports: cond, flags in; result out. Shared with conditional-move logic.
module jmp_cond_eval
    import jrb8_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       result
);

    logic z, o, c, s, lt;

    assign z  = flags[FLAG_Z];
    assign o  = flags[FLAG_O];
    assign c  = flags[FLAG_C];
    assign s  = flags[FLAG_S];
    // Signed less-than after a compare
    assign lt = s ^ o;

    always_comb begin
        result = 1'b0;
        case (cond)
            COND_ALWAYS: result = 1'b1;
            COND_EQ:     result = z;
            COND_NE:     result = !z;
            COND_LT:     result = lt;
            COND_LE:     result = z | lt;
            COND_GT:     result = !z & !lt;
            COND_GE:     result = !lt;
            COND_C:      result = c;
            COND_NC:     result = !c;
            COND_O:      result = o;
            COND_NO:     result = !o;
            COND_S:      result = s;
            COND_NS:     result = !s;
            COND_HI:     result = !c & !z;
            COND_LS:     result = c | z;
            default:     result = 1'b0;
        endcase
    end

endmodule

// File: rtl/jmp_unit.sv
// Branch-resolution stage: latches cond/flags, fetches 1 or 2 target bytes
// (rd_req/rd_valid/rd_data), pulses pc_inc per byte, then commits in one
// cycle with done/taken/pc_load and pc_next. busy is high outside IDLE.
module jmp_unit
    import jrb8_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jmp_req,
    input  logic [3:0]        cond,
    input  logic [3:0]        flags,
    output logic              rd_req,
    input  logic              rd_valid,
    input  logic [7:0]        rd_data,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    output logic              taken,
    output logic              done,
    output logic              busy
);

    logic [1:0] state;
    logic [3:0] cond_q;
    logic [3:0] flags_q;
    logic [7:0] hi_q;
    logic       inc_q;
    logic       cres;

    jmp_cond_eval u_eval (
        .cond   (cond_q),
        .flags  (flags_q),
        .result (cres)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cond_q  <= '0;
            flags_q <= '0;
            hi_q    <= '0;
            inc_q   <= 1'b0;
            pc_next <= '0;
        end else begin
            inc_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (jmp_req) begin
                        cond_q  <= cond;
                        flags_q <= flags;
                        state   <= (ADDR_W == 16) ? ST_FETCH_HI
                                                  : ST_FETCH_LO;
                    end
                end
                ST_FETCH_HI: begin
                    if (rd_valid) begin
                        hi_q  <= rd_data;
                        inc_q <= 1'b1;
                        state <= ST_FETCH_LO;
                    end
                end
                ST_FETCH_LO: begin
                    if (rd_valid) begin
                        // Narrow build keeps only the low byte
                        pc_next <= ADDR_W'({hi_q, rd_data});
                        inc_q   <= 1'b1;
                        state   <= ST_COMMIT;
                    end
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign rd_req  = (state == ST_FETCH_HI) || (state == ST_FETCH_LO);
    assign done    = (state == ST_COMMIT);
    assign taken   = done & cres;
    assign pc_load = taken;
    assign pc_inc  = inc_q;
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_jmp_unit.sv
// Testbench for jmp_unit: 16-bit and 8-bit instances, table vectors,
// random sequences against a flag-semantics model, and corner sequences.
module tb_jmp_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       jreq = 1'b0;
    logic       sel8 = 1'b0;
    logic [3:0] cond = '0;
    logic [3:0] flags = '0;
    logic       rd_valid = 1'b0;
    logic [7:0] rd_data = '0;

    logic        rd_req16, pc_inc16, pc_load16, taken16, done16, busy16;
    logic [15:0] pc_next16;
    logic        rd_req8, pc_inc8, pc_load8, taken8, done8, busy8;
    logic [7:0]  pc_next8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jmp_unit #(.ADDR_W(16)) u16 (
        .clk(clk), .rst_n(rst_n), .jmp_req(jreq & !sel8),
        .cond(cond), .flags(flags), .rd_req(rd_req16),
        .rd_valid(rd_valid), .rd_data(rd_data), .pc_inc(pc_inc16),
        .pc_load(pc_load16), .pc_next(pc_next16), .taken(taken16),
        .done(done16), .busy(busy16)
    );

    jmp_unit #(.ADDR_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .jmp_req(jreq & sel8),
        .cond(cond), .flags(flags), .rd_req(rd_req8),
        .rd_valid(rd_valid), .rd_data(rd_data), .pc_inc(pc_inc8),
        .pc_load(pc_load8), .pc_next(pc_next8), .taken(taken8),
        .done(done8), .busy(busy8)
    );

    wire        rd_req_o  = sel8 ? rd_req8  : rd_req16;
    wire        pc_inc_o  = sel8 ? pc_inc8  : pc_inc16;
    wire        pc_load_o = sel8 ? pc_load8 : pc_load16;
    wire        taken_o   = sel8 ? taken8   : taken16;
    wire        done_o    = sel8 ? done8    : done16;
    wire        busy_o    = sel8 ? busy8    : busy16;
    wire [15:0] pcn_o     = sel8 ? {8'h00, pc_next8} : pc_next16;

    typedef struct {
        bit         s8;
        logic [3:0] c;
        logic [3:0] f;
        logic [7:0] hi;
        logic [7:0] lo;
        int         w;
        logic       t;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: flags {Z,O,C,S} read as the outcome of a compare
    function automatic logic ref_taken(input logic [3:0] c,
                                       input logic [3:0] f);
        bit eq, ov, cy, ng, sless, uless_eq;
        eq = f[3]; ov = f[2]; cy = f[1]; ng = f[0];
        sless    = (ng != ov);
        uless_eq = cy || eq;
        case (int'(c))
            0:  return 1'b1;
            1:  return eq;
            2:  return !eq;
            3:  return sless;
            4:  return sless || eq;
            5:  return !(sless || eq);
            6:  return !sless;
            7:  return cy;
            8:  return !cy;
            9:  return ov;
            10: return !ov;
            11: return ng;
            12: return !ng;
            13: return !uless_eq;
            14: return uless_eq;
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_seq(input bit s8, input logic [3:0] c,
                           input logic [3:0] f, input logic [7:0] hi,
                           input logic [7:0] lo, input int w,
                           input logic exp_t, input string nm);
        int k, done_k, incs, loads, bi, wc;
        logic t_seen;
        logic [15:0] pcn_seen, exp_pc;
        bit bsy_ok;
        sel8 = s8;
        jreq = 1'b1;
        cond = c;
        flags = f;
        rd_valid = 1'($urandom);
        rd_data = 8'($urandom);
        #1;
        chk($sformatf("%s_idle", nm), {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        jreq = 1'b0;
        flags = ~f;
        cond = ~c;
        k = 1; done_k = 0; incs = 0; loads = 0; bi = 0; wc = 0;
        bsy_ok = 1'b1; t_seen = 1'b0; pcn_seen = '0;
        while (done_k == 0 && k < 64) begin
            if (!busy_o) bsy_ok = 1'b0;
            if (pc_inc_o) incs++;
            if (pc_load_o) loads++;
            if (done_o) begin
                done_k = k;
                t_seen = taken_o;
                pcn_seen = pcn_o;
            end
            rd_valid = 1'b0;
            rd_data = 8'($urandom);
            if (rd_req_o) begin
                if (wc == w) begin
                    rd_valid = 1'b1;
                    rd_data = (s8 || bi != 0) ? lo : hi;
                    bi++;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
            if (done_o) begin
                jreq = 1'($urandom);
                rd_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            k++;
        end
        jreq = 1'b0;
        rd_valid = 1'b0;
        exp_pc = s8 ? {8'h00, lo} : {hi, lo};
        chk($sformatf("%s_lat", nm), done_k, s8 ? 2 + w : 3 + 2 * w);
        chk($sformatf("%s_taken", nm), {31'd0, t_seen}, {31'd0, exp_t});
        chk($sformatf("%s_loads", nm), loads, {31'd0, exp_t});
        chk($sformatf("%s_incs", nm), incs, s8 ? 1 : 2);
        chk($sformatf("%s_pcnext", nm), {16'd0, pcn_seen}, {16'd0, exp_pc});
        chk($sformatf("%s_busy", nm), {31'd0, bsy_ok}, 32'd1);
        chk($sformatf("%s_after", nm),
            {29'd0, busy_o, done_o, pc_inc_o}, 32'd0);
    endtask

    initial begin
        int dones, loads, tks, last, first;
        tbl[0]  = '{0, 4'h0, 4'b0000, 8'h12, 8'h34, 0, 1'b1};
        tbl[1]  = '{0, 4'h1, 4'b0000, 8'hAB, 8'hCD, 0, 1'b0};
        tbl[2]  = '{0, 4'h1, 4'b1000, 8'h01, 8'h02, 0, 1'b1};
        tbl[3]  = '{0, 4'h3, 4'b0001, 8'hC3, 8'h3C, 2, 1'b1};
        tbl[4]  = '{0, 4'h3, 4'b0101, 8'h55, 8'hAA, 0, 1'b0};
        tbl[5]  = '{0, 4'h5, 4'b0000, 8'h10, 8'h20, 1, 1'b1};
        tbl[6]  = '{0, 4'h5, 4'b1000, 8'h30, 8'h40, 0, 1'b0};
        tbl[7]  = '{0, 4'hD, 4'b0000, 8'hFF, 8'hFE, 0, 1'b1};
        tbl[8]  = '{0, 4'hE, 4'b0010, 8'h80, 8'h01, 0, 1'b1};
        tbl[9]  = '{0, 4'hF, 4'b1111, 8'h77, 8'h88, 0, 1'b0};
        tbl[10] = '{0, 4'h9, 4'b0100, 8'h0F, 8'hF0, 0, 1'b1};
        tbl[11] = '{0, 4'hC, 4'b0001, 8'h11, 8'h22, 0, 1'b0};
        tbl[12] = '{1, 4'h7, 4'b0010, 8'h00, 8'h5A, 0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy16", {31'd0, busy16}, 32'd0);
        chk("rst_pc16", {16'd0, pc_next16}, 32'd0);
        chk("rst_outs16", {27'd0, rd_req16, pc_inc16, pc_load16,
                           taken16, done16}, 32'd0);
        chk("rst_pc8", {24'd0, pc_next8}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i])
            run_seq(tbl[i].s8, tbl[i].c, tbl[i].f, tbl[i].hi, tbl[i].lo,
                    tbl[i].w, tbl[i].t, $sformatf("tbl%0d", i));

        // Reset while waiting for the low byte
        sel8 = 1'b0; jreq = 1'b1; cond = 4'h0; flags = 4'h0;
        @(posedge clk); #1;
        jreq = 1'b0; rd_valid = 1'b1; rd_data = 8'h77;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        chk("rst_mid_inlo", {31'd0, rd_req16}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy16}, 32'd0);
        chk("rst_mid_pc", {16'd0, pc_next16}, 32'd0);
        chk("rst_mid_outs", {28'd0, rd_req16, pc_inc16, pc_load16,
                             done16}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_valid = 1'b1;
        loads = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (pc_load16 || busy16) loads++;
        end
        rd_valid = 1'b0;
        chk("rst_mid_quiet", loads, 0);
        run_seq(0, 4'h0, 4'h0, 8'hBE, 8'hEF, 0, 1'b1, "post_rst");

        // jmp_req held high with cond=never
        sel8 = 1'b0; jreq = 1'b1; cond = 4'hF; rd_valid = 1'b1;
        dones = 0; loads = 0; tks = 0; last = 0; first = 0;
        for (int i = 1; i <= 16; i++) begin
            flags = 4'($urandom);
            rd_data = 8'($urandom);
            @(posedge clk); #1;
            if (i == 16) begin
                jreq = 1'b0;
                rd_valid = 1'b0;
            end
            if (pc_load16) loads++;
            if (taken16) tks++;
            if (done16) begin
                dones++;
                if (first == 0) first = i;
                if (last != 0) chk("held_gap", i - last, 4);
                last = i;
            end
        end
        chk("held_dones", dones, 4);
        chk("held_first", first, 3);
        chk("held_loads", loads, 0);
        chk("held_taken", tks, 0);
        @(posedge clk); #1;
        chk("held_idle", {31'd0, busy16}, 32'd0);

        // Random sequences against the flag model
        for (int n = 0; n < 40; n++) begin
            bit s8;
            logic [3:0] c, f;
            s8 = ($urandom_range(0, 3) == 0);
            c = 4'($urandom);
            f = 4'($urandom);
            run_seq(s8, c, f, 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 2)), ref_taken(c, f),
                    $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/jmp_unit.md
Name: jmp_unit

Overview:
- Branch-resolution stage directly downstream of the compare/flags register.
- Consumes the Z/O/C/S flags and a 4-bit condition code from the decoder.
- Fetches the 8- or 16-bit jump target operand bytes over a simple read handshake and advances the PC past each byte.
- Commits a PC load when the condition holds; otherwise execution falls through.

Parameters:
- ADDR_W, 16, target/PC width; legal values 8 (one operand byte) or 16 (two bytes, high byte first).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- jmp_req  input  1  start a jump sequence; accepted only when busy=0
- cond  input  4  condition code, sampled on acceptance
- flags  input  4  {Z,O,C,S} from the flags register, sampled on acceptance
- rd_req  output  1  operand byte requested
- rd_valid  input  1  rd_data valid; meaningful only while rd_req=1
- rd_data  input  8  operand byte
- pc_inc  output  1  one-cycle pulse per operand byte accepted
- pc_load  output  1  one-cycle pulse: load pc_next into the PC
- pc_next  output  ADDR_W  jump target; holds its value between commits
- taken  output  1  condition result, valid while done=1
- done  output  1  one-cycle pulse at end of every sequence
- busy  output  1  high in any state except IDLE

Behaviour:
- States: IDLE, FETCH_HI, FETCH_LO, COMMIT.
  - All outputs are decoded from registered state and data; no input-to-output combinational paths.
- Reset (async, rst_n=0): state=IDLE; pc_next=0; snapshot registers=0; rd_req, pc_inc, pc_load, done, taken, busy all 0. Reset mid-sequence abandons it with no pc_load.
- IDLE:
  - On jmp_req=1 at a clock edge, latch cond and flags.
  - Go to FETCH_HI when ADDR_W=16, or FETCH_LO when ADDR_W=8.
- FETCH_HI / FETCH_LO:
  - rd_req=1.
  - On an edge with rd_valid=1, store rd_data in the high or low target byte, pulse pc_inc in the following cycle, and advance (FETCH_HI to FETCH_LO, FETCH_LO to COMMIT).
  - rd_valid=0 means wait indefinitely; no timeout.
- COMMIT (one cycle):
  - done=1; taken=cond_result.
  - pc_load=taken, with pc_next={hi,lo} updated at entry.
  - Return to IDLE.
- Operands are always fetched, even when the condition is false or "never", so the PC skips them.
- Condition results use the latched flags:
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 S^O
  - 4 Z|(S^O)
  - 5 !Z&!(S^O)
  - 6 !(S^O)
  - 7 C
  - 8 !C
  - 9 O
  - A !O
  - B S
  - C !S
  - D !C&!Z
  - E C|Z
  - F never
- Flag changes after acceptance have no effect on the result.
- Boundary cases:
  - jmp_req while busy=1: ignored; not queued.
  - rd_valid while rd_req=0: ignored.
  - jmp_req during COMMIT: ignored; a new sequence is accepted only from IDLE.
- Timing:
  - Minimum latency from acceptance edge to done: 3 cycles for ADDR_W=16, 2 cycles for ADDR_W=8, with zero-wait rd_valid.
  - Back-to-back throughput: one jump per 4 cycles (16-bit).
- When the condition is not taken, pc_next still updates to the fetched target (debug visibility), but pc_load stays 0.

Decomposition:
- Shared package jrb8_pkg:
  - condition-code localparams (COND_ALWAYS to COND_NEVER)
  - flag bit indices (FLAG_Z=3, FLAG_O=2, FLAG_C=1, FLAG_S=0)
  - FSM state encoding
- Sub-module jmp_cond_eval: purely combinational cond x flags to result. Reused later by conditional-move logic.

Test Plan:
- Reset mid-FETCH_LO: assert rst_n=0 -> state IDLE, busy=0, pc_next=0, no pc_load pulse; the next jmp_req starts a fresh sequence.
- cond=0, bytes 0x12,0x34 with zero-wait rd_valid -> two pc_inc pulses; done, taken=1 and pc_load=1 exactly 3 cycles after acceptance; pc_next=0x1234.
- cond=1, flags Z=0; bytes 0xAB,0xCD -> done=1, taken=0, pc_load=0, two pc_inc pulses, pc_next=0xABCD.
- cond=3, flags S=1,O=0 latched; flags change to S=0 during fetch; 2 wait cycles per byte -> taken=1, pc_next from bytes, busy high throughout the 7 cycles.
- jmp_req held high continuously with cond=F -> exactly one sequence per 4 cycles, taken=0 every time, requests during busy ignored.
- ADDR_W=8, cond=7, C=1, byte 0x5A -> one pc_inc, done 2 cycles after acceptance, pc_load=1, pc_next=0x5A.
